axi_master_mux: RTL and testbench

AXI_MASTER_MUX -- requirements
Module: axi_master_mux

---
 rtl/axi_master_mux.sv | 320 ++++++++++++++++++++++++++++++++
 tb/tb_axi_master_mux.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_master_mux.sv
// axi_master_mux
// Multiplexes NM AXI4 masters onto one AXI4 slave port. The write and read
// paths each have their own arbiter and FSM, so one master may hold both
// grants at once. The grant index is prepended to the master ID on the way
// out. On the way back it routes the response to the current grant only.
// The grant is not taken from the returned ID bits. If those bits disagree
// with the grant, the sticky id_err flag is set.
//
// Ports
//   clock, reset     : rising-edge clock, asynchronous active-high reset
//   m_aw*/m_w*/m_b*  : per-master write channels, master i at slice i
//   m_ar*/m_r*       : per-master read channels, master i at slice i
//   s_aw*..s_r*      : single slave-side port, ID width SIDW = IDW+$clog2(NM)
//   id_err           : sticky, set when a response ID does not match the grant
//
// Configuration
//   AXI_MUX_RR_EN    : defined   -> round-robin arbiters with pointer registers
//                      undefined -> fixed priority, lowest index wins
module axi_master_mux #(
  parameter  int NM   = 3,
  parameter  int AW   = 32,
  parameter  int DW   = 64,
  parameter  int IDW  = 4,
  localparam int GW   = $clog2(NM),
  localparam int SIDW = IDW + GW
) (
  input  logic                  clock,
  input  logic                  reset,
  // master write address
  input  logic [NM-1:0]         m_awvalid,
  output logic [NM-1:0]         m_awready,
  input  logic [NM*IDW-1:0]     m_awid,
  input  logic [NM*AW-1:0]      m_awaddr,
  input  logic [NM*8-1:0]       m_awlen,
  input  logic [NM*3-1:0]       m_awsize,
  input  logic [NM*2-1:0]       m_awburst,
  // master write data
  input  logic [NM-1:0]         m_wvalid,
  output logic [NM-1:0]         m_wready,
  input  logic [NM*DW-1:0]      m_wdata,
  input  logic [NM*(DW/8)-1:0]  m_wstrb,
  input  logic [NM-1:0]         m_wlast,
  // master write response
  output logic [NM-1:0]         m_bvalid,
  input  logic [NM-1:0]         m_bready,
  output logic [NM*IDW-1:0]     m_bid,
  output logic [NM*2-1:0]       m_bresp,
  // master read address
  input  logic [NM-1:0]         m_arvalid,
  output logic [NM-1:0]         m_arready,
  input  logic [NM*IDW-1:0]     m_arid,
  input  logic [NM*AW-1:0]      m_araddr,
  input  logic [NM*8-1:0]       m_arlen,
  input  logic [NM*3-1:0]       m_arsize,
  input  logic [NM*2-1:0]       m_arburst,
  // master read data
  output logic [NM-1:0]         m_rvalid,
  input  logic [NM-1:0]         m_rready,
  output logic [NM*IDW-1:0]     m_rid,
  output logic [NM*DW-1:0]      m_rdata,
  output logic [NM*2-1:0]       m_rresp,
  output logic [NM-1:0]         m_rlast,
  // slave write address
  output logic                  s_awvalid,
  input  logic                  s_awready,
  output logic [SIDW-1:0]       s_awid,
  output logic [AW-1:0]         s_awaddr,
  output logic [7:0]            s_awlen,
  output logic [2:0]            s_awsize,
  output logic [1:0]            s_awburst,
  // slave write data
  output logic                  s_wvalid,
  input  logic                  s_wready,
  output logic [DW-1:0]         s_wdata,
  output logic [DW/8-1:0]       s_wstrb,
  output logic                  s_wlast,
  // slave write response
  input  logic                  s_bvalid,
  output logic                  s_bready,
  input  logic [SIDW-1:0]       s_bid,
  input  logic [1:0]            s_bresp,
  // slave read address
  output logic                  s_arvalid,
  input  logic                  s_arready,
  output logic [SIDW-1:0]       s_arid,
  output logic [AW-1:0]         s_araddr,
  output logic [7:0]            s_arlen,
  output logic [2:0]            s_arsize,
  output logic [1:0]            s_arburst,
  // slave read data
  input  logic                  s_rvalid,
  output logic                  s_rready,
  input  logic [SIDW-1:0]       s_rid,
  input  logic [DW-1:0]         s_rdata,
  input  logic [1:0]            s_rresp,
  input  logic                  s_rlast,
  // status
  output logic                  id_err
);

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_ADDR = 2'd1,
    W_DATA = 2'd2,
    W_RESP = 2'd3
  } wstate_t;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rstate_t;

  wstate_t         w_state_r, w_next_s;
  rstate_t         r_state_r, r_next_s;
  logic [GW-1:0]   wg_r, rg_r;
  logic            w_done_s, r_done_s;
  logic            w_id_bad_s, r_id_bad_s;
  logic            id_err_r;

`ifdef AXI_MUX_RR_EN
  logic [GW-1:0]   wp_r, rp_r;

  // The search starts at ptr. The loop runs downwards so that the last hit is
  // the one nearest to ptr.
  function automatic logic [GW-1:0] arb_pick(input logic [NM-1:0] req,
                                             input logic [GW-1:0] ptr);
    logic [GW-1:0] res;
    int            idx;
    res = ptr;
    for (int k = NM - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NM;
      if (req[idx]) res = GW'(idx);
      else          res = res;
    end
    return res;
  endfunction

  function automatic logic [GW-1:0] ptr_next(input logic [GW-1:0] g);
    logic [GW-1:0] res;
    if (g == GW'(NM - 1)) res = {GW{1'b0}};
    else                  res = g + GW'(1);
    return res;
  endfunction
`else
  // Fixed priority. The loop runs downwards so that the lowest requesting
  // index is the last one written.
  function automatic logic [GW-1:0] arb_pick(input logic [NM-1:0] req);
    logic [GW-1:0] res;
    res = {GW{1'b0}};
    for (int i = NM - 1; i >= 0; i--) begin
      if (req[i]) res = GW'(i);
      else        res = res;
    end
    return res;
  endfunction
`endif

  // Slave-side payload follows the grant. A valid is driven only in the
  // state that owns the channel, so the payload outside that state is
  // harmless.
  assign s_awid    = {wg_r, m_awid[wg_r*IDW +: IDW]};
  assign s_awaddr  = m_awaddr[wg_r*AW +: AW];
  assign s_awlen   = m_awlen[wg_r*8 +: 8];
  assign s_awsize  = m_awsize[wg_r*3 +: 3];
  assign s_awburst = m_awburst[wg_r*2 +: 2];
  assign s_wdata   = m_wdata[wg_r*DW +: DW];
  assign s_wstrb   = m_wstrb[wg_r*(DW/8) +: (DW/8)];
  assign s_wlast   = m_wlast[wg_r];
  assign s_arid    = {rg_r, m_arid[rg_r*IDW +: IDW]};
  assign s_araddr  = m_araddr[rg_r*AW +: AW];
  assign s_arlen   = m_arlen[rg_r*8 +: 8];
  assign s_arsize  = m_arsize[rg_r*3 +: 3];
  assign s_arburst = m_arburst[rg_r*2 +: 2];
  assign id_err    = id_err_r;

  // Write FSM next state and channel routing
  always_comb begin
    w_next_s   = w_state_r;
    w_done_s   = 1'b0;
    w_id_bad_s = 1'b0;
    s_awvalid  = 1'b0;
    s_wvalid   = 1'b0;
    s_bready   = 1'b0;
    m_awready  = '0;
    m_wready   = '0;
    m_bvalid   = '0;
    m_bid      = '0;
    m_bresp    = '0;
    case (w_state_r)
      W_IDLE: begin
        if (|m_awvalid) w_next_s = W_ADDR;
        else            w_next_s = W_IDLE;
      end
      W_ADDR: begin
        s_awvalid       = m_awvalid[wg_r];
        m_awready[wg_r] = s_awready;
        if (m_awvalid[wg_r] && s_awready) w_next_s = W_DATA;
        else                              w_next_s = W_ADDR;
      end
      W_DATA: begin
        s_wvalid       = m_wvalid[wg_r];
        m_wready[wg_r] = s_wready;
        if (m_wvalid[wg_r] && s_wready && m_wlast[wg_r]) w_next_s = W_RESP;
        else                                             w_next_s = W_DATA;
      end
      W_RESP: begin
        m_bvalid[wg_r]            = s_bvalid;
        m_bid[wg_r*IDW +: IDW]    = s_bid[IDW-1:0];
        m_bresp[wg_r*2 +: 2]      = s_bresp;
        s_bready                  = m_bready[wg_r];
        w_id_bad_s                = s_bvalid && (s_bid[SIDW-1:IDW] != wg_r);
        w_done_s                  = s_bvalid && m_bready[wg_r];
        if (w_done_s) w_next_s = W_IDLE;
        else          w_next_s = W_RESP;
      end
      default: begin
        w_next_s = W_IDLE;
      end
    endcase
  end

  // Read FSM next state and channel routing
  always_comb begin
    r_next_s   = r_state_r;
    r_done_s   = 1'b0;
    r_id_bad_s = 1'b0;
    s_arvalid  = 1'b0;
    s_rready   = 1'b0;
    m_arready  = '0;
    m_rvalid   = '0;
    m_rid      = '0;
    m_rdata    = '0;
    m_rresp    = '0;
    m_rlast    = '0;
    case (r_state_r)
      R_IDLE: begin
        if (|m_arvalid) r_next_s = R_ADDR;
        else            r_next_s = R_IDLE;
      end
      R_ADDR: begin
        s_arvalid       = m_arvalid[rg_r];
        m_arready[rg_r] = s_arready;
        if (m_arvalid[rg_r] && s_arready) r_next_s = R_DATA;
        else                              r_next_s = R_ADDR;
      end
      R_DATA: begin
        m_rvalid[rg_r]          = s_rvalid;
        m_rid[rg_r*IDW +: IDW]  = s_rid[IDW-1:0];
        m_rdata[rg_r*DW +: DW]  = s_rdata;
        m_rresp[rg_r*2 +: 2]    = s_rresp;
        m_rlast[rg_r]           = s_rlast;
        s_rready                = m_rready[rg_r];
        r_id_bad_s              = s_rvalid && (s_rid[SIDW-1:IDW] != rg_r);
        r_done_s                = s_rvalid && m_rready[rg_r] && s_rlast;
        if (r_done_s) r_next_s = R_IDLE;
        else          r_next_s = R_DATA;
      end
      default: begin
        r_next_s = R_IDLE;
      end
    endcase
  end

  // Write state, grant capture in W_IDLE, and the optional RR pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      w_state_r <= W_IDLE;
      wg_r      <= {GW{1'b0}};
`ifdef AXI_MUX_RR_EN
      wp_r      <= {GW{1'b0}};
`endif
    end else begin
      w_state_r <= w_next_s;
`ifdef AXI_MUX_RR_EN
      if (w_state_r == W_IDLE && |m_awvalid) wg_r <= arb_pick(m_awvalid, wp_r);
      else                                   wg_r <= wg_r;
      if (w_done_s) wp_r <= ptr_next(wg_r);
      else          wp_r <= wp_r;
`else
      if (w_state_r == W_IDLE && |m_awvalid) wg_r <= arb_pick(m_awvalid);
      else                                   wg_r <= wg_r;
`endif
    end
  end

  // Read state, grant capture in R_IDLE, and the optional RR pointer
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state_r <= R_IDLE;
      rg_r      <= {GW{1'b0}};
`ifdef AXI_MUX_RR_EN
      rp_r      <= {GW{1'b0}};
`endif
    end else begin
      r_state_r <= r_next_s;
`ifdef AXI_MUX_RR_EN
      if (r_state_r == R_IDLE && |m_arvalid) rg_r <= arb_pick(m_arvalid, rp_r);
      else                                   rg_r <= rg_r;
      if (r_done_s) rp_r <= ptr_next(rg_r);
      else          rp_r <= rp_r;
`else
      if (r_state_r == R_IDLE && |m_arvalid) rg_r <= arb_pick(m_arvalid);
      else                                   rg_r <= rg_r;
`endif
    end
  end

  // Sticky response-ID mismatch flag, cleared only by reset
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      id_err_r <= 1'b0;
    end else if (w_id_bad_s || r_id_bad_s) begin
      id_err_r <= 1'b1;
    end else begin
      id_err_r <= id_err_r;
    end
  end

endmodule

// File: tb/tb_axi_master_mux.sv
// Directed testbench for axi_master_mux (NM=3, AW=32, DW=64, IDW=4).
// The slave side is driven directly from the stimulus. Expected values are
// hand-computed constants. Reads use the round-robin order when
// AXI_MUX_RR_EN is defined.
module tb_axi_master_mux;

  localparam int NM = 3, AW = 32, DW = 64, IDW = 4, SIDW = 6;

  logic clock, reset;
  logic [NM-1:0] m_awvalid, m_awready, m_wvalid, m_wready, m_wlast;
  logic [NM-1:0] m_bvalid, m_bready, m_arvalid, m_arready;
  logic [NM-1:0] m_rvalid, m_rready, m_rlast;
  logic [NM*IDW-1:0] m_awid, m_bid, m_arid, m_rid;
  logic [NM*AW-1:0] m_awaddr, m_araddr;
  logic [NM*8-1:0] m_awlen, m_arlen;
  logic [NM*3-1:0] m_awsize, m_arsize;
  logic [NM*2-1:0] m_awburst, m_arburst, m_bresp, m_rresp;
  logic [NM*DW-1:0] m_wdata, m_rdata;
  logic [NM*(DW/8)-1:0] m_wstrb;
  logic s_awvalid, s_awready, s_wvalid, s_wready, s_wlast, s_bvalid, s_bready;
  logic s_arvalid, s_arready, s_rvalid, s_rready, s_rlast, id_err;
  logic [SIDW-1:0] s_awid, s_bid, s_arid, s_rid;
  logic [AW-1:0] s_awaddr, s_araddr;
  logic [7:0] s_awlen, s_arlen;
  logic [2:0] s_awsize, s_arsize;
  logic [1:0] s_awburst, s_arburst, s_bresp, s_rresp;
  logic [DW-1:0] s_wdata, s_rdata;
  logic [DW/8-1:0] s_wstrb;
  logic [19:0] vr_s;

  int total = 0;
  int bad = 0;
  int exp_g[3];

  axi_master_mux #(.NM(NM), .AW(AW), .DW(DW), .IDW(IDW)) dut (
    .clock(clock), .reset(reset),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awid(m_awid),
    .m_awaddr(m_awaddr), .m_awlen(m_awlen), .m_awsize(m_awsize),
    .m_awburst(m_awburst),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata),
    .m_wstrb(m_wstrb), .m_wlast(m_wlast),
    .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bid(m_bid), .m_bresp(m_bresp),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_arid(m_arid),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize),
    .m_arburst(m_arburst),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rid(m_rid),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awid(s_awid),
    .s_awaddr(s_awaddr), .s_awlen(s_awlen), .s_awsize(s_awsize),
    .s_awburst(s_awburst),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata),
    .s_wstrb(s_wstrb), .s_wlast(s_wlast),
    .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bid(s_bid), .s_bresp(s_bresp),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_arid(s_arid),
    .s_araddr(s_araddr), .s_arlen(s_arlen), .s_arsize(s_arsize),
    .s_arburst(s_arburst),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rid(s_rid),
    .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rlast(s_rlast),
    .id_err(id_err)
  );

  assign vr_s = {m_awready, m_wready, m_bvalid, m_arready, m_rvalid,
                 s_awvalid, s_wvalid, s_bready, s_arvalid, s_rready};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One read transaction. It is entered at a negedge with the read FSM idle
  // and the requests already driven. It returns at a negedge, idle again.
  task automatic rd_txn(input int g);
    #1 check("ar_idle_rdy", 64'(m_arready), 64'd0);
    @(negedge clock); #1;
    check("ar_grant_id", 64'(s_arid), 64'((g << 4) | (g + 8)));
    check("ar_ready_route", 64'(m_arready), 64'(1 << g));
    @(negedge clock);
    s_rvalid = 1'b1; s_rid = 6'((g << 4) | (g + 8));
    s_rdata = 64'hB0 + 64'(g); s_rlast = 1'b1;
    #1;
    check("r_valid_route", 64'(m_rvalid), 64'(1 << g));
    check("r_data_route", m_rdata[g*64 +: 64], 64'hB0 + 64'(g));
    check("r_last_route", 64'(m_rlast), 64'(1 << g));
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0;
  endtask

  initial begin
`ifdef AXI_MUX_RR_EN
    exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 2;
`else
    exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0;
`endif
    reset = 1'b1;
    m_awvalid = '0; m_awid = '0; m_awaddr = '0; m_awlen = '0; m_awsize = '0;
    m_awburst = '0; m_wvalid = '0; m_wdata = '0; m_wstrb = '0; m_wlast = '0;
    m_bready = 3'b111; m_arvalid = '0; m_araddr = '0; m_arlen = '0;
    m_arsize = '0; m_arburst = '0; m_rready = 3'b111;
    m_arid = {4'd10, 4'd9, 4'd8};
    s_awready = 1'b1; s_wready = 1'b1; s_arready = 1'b1;
    s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    s_rvalid = 1'b0; s_rid = '0; s_rdata = '0; s_rresp = '0; s_rlast = 1'b0;

    // reset state
    repeat (2) @(negedge clock);
    #1;
    check("rst_vr", 64'(vr_s), 64'd0);
    check("rst_id_err", 64'(id_err), 64'd0);
    @(negedge clock); reset = 1'b0;

    // master 1 write, len=3, id=5, addr 0x1000
    @(negedge clock);
    m_awvalid = 3'b010; m_awid[7:4] = 4'd5; m_awaddr[63:32] = 32'h1000;
    m_awlen[15:8] = 8'd3; m_awsize[5:3] = 3'd3; m_awburst[3:2] = 2'd1;
    #1;
    check("w_idle_awready", 64'(m_awready), 64'd0);
    check("w_idle_s_awvalid", 64'(s_awvalid), 64'd0);
    @(negedge clock); #1;
    check("aw_valid", 64'(s_awvalid), 64'd1);
    check("aw_id", 64'(s_awid), 64'h15);
    check("aw_addr", 64'(s_awaddr), 64'h1000);
    check("aw_len", 64'(s_awlen), 64'd3);
    check("aw_ready_route", 64'(m_awready), 64'b010);
    @(negedge clock);
    m_awvalid = '0; m_wvalid = 3'b010; m_wstrb[15:8] = 8'hF0;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) @(negedge clock);
      m_wdata[127:64] = 64'hA000 + 64'(b);
      m_wlast = (b == 3) ? 3'b010 : 3'b000;
      #1;
      check("w_data", s_wdata, 64'hA000 + 64'(b));
      check("w_last", 64'(s_wlast), (b == 3) ? 64'd1 : 64'd0);
      check("w_ready_route", 64'(m_wready), 64'b010);
    end
    check("w_strb", 64'(s_wstrb), 64'hF0);
    @(negedge clock);
    m_wvalid = '0; m_wlast = '0;
    s_bvalid = 1'b1; s_bid = 6'h15; s_bresp = 2'b10;
    #1;
    check("b_valid_route", 64'(m_bvalid), 64'b010);
    check("b_id_route", 64'(m_bid), 64'h050);
    check("b_resp_route", 64'(m_bresp), 64'b001000);
    check("b_ready", 64'(s_bready), 64'd1);
    @(negedge clock);
    s_bvalid = 1'b0; s_bid = '0; s_bresp = '0;
    #1;
    check("b_done", 64'(m_bvalid), 64'd0);
    check("b_no_id_err", 64'(id_err), 64'd0);

    // all three masters request AR together
    @(negedge clock);
    m_arvalid = 3'b111;
    for (int k = 0; k < 3; k++) rd_txn(exp_g[k]);
    m_arvalid = '0;

    // concurrent: master 0 writes (len=0, id=2), master 2 reads (id=10)
    @(negedge clock);
    m_awvalid = 3'b001; m_awid[3:0] = 4'd2; m_awlen[7:0] = 8'd0;
    m_arvalid = 3'b100;
    @(negedge clock); #1;
    check("cc_awvalid", 64'(s_awvalid), 64'd1);
    check("cc_arvalid", 64'(s_arvalid), 64'd1);
    check("cc_awready", 64'(m_awready), 64'b001);
    check("cc_arready", 64'(m_arready), 64'b100);
    check("cc_arid", 64'(s_arid), 64'h2A);
    @(negedge clock);
    m_awvalid = '0; m_arvalid = '0;
    m_wvalid = 3'b001; m_wlast = 3'b001; m_wdata[63:0] = 64'h55;
    s_rvalid = 1'b1; s_rid = 6'h2A; s_rdata = 64'h77; s_rlast = 1'b1;
    #1;
    check("cc_wvalid", 64'(s_wvalid), 64'd1);
    check("cc_rvalid", 64'(m_rvalid), 64'b100);
    @(negedge clock);
    m_wvalid = '0; m_wlast = '0; s_rvalid = 1'b0; s_rlast = 1'b0;
    s_bvalid = 1'b1; s_bid = 6'h02;
    #1;
    check("cc_bvalid", 64'(m_bvalid), 64'b001);
    check("cc_r_done", 64'(m_rvalid), 64'd0);
    @(negedge clock);
    s_bvalid = 1'b0;
    #1 check("cc_b_done", 64'(m_bvalid), 64'd0);

    // response ID upper bits 2 while the read grant is 0
    @(negedge clock);
    m_arvalid = 3'b001;
    @(negedge clock); #1;
    check("ie_arid", 64'(s_arid), 64'h08);
    @(negedge clock);
    m_arvalid = '0;
    s_rvalid = 1'b1; s_rid = 6'h23; s_rdata = 64'hDEAD; s_rlast = 1'b1;
    #1;
    check("ie_rvalid", 64'(m_rvalid), 64'b001);
    check("ie_rdata0", m_rdata[63:0], 64'hDEAD);
    check("ie_rdata2", m_rdata[191:128], 64'd0);
    check("ie_rid", 64'(m_rid), 64'h003);
    @(negedge clock);
    s_rvalid = 1'b0; s_rlast = 1'b0;
    #1 check("ie_set", 64'(id_err), 64'd1);
    repeat (2) @(negedge clock);
    #1 check("ie_sticky", 64'(id_err), 64'd1);

    // reset during the 2nd W beat of a len=7 burst
    @(negedge clock);
    m_awvalid = 3'b001; m_awlen[7:0] = 8'd7;
    @(negedge clock); #1;
    check("rb_awlen", 64'(s_awlen), 64'd7);
    @(negedge clock);
    m_awvalid = '0; m_wvalid = 3'b001; m_wdata[63:0] = 64'h100;
    @(negedge clock);
    m_wdata[63:0] = 64'h101;
    #1 check("rb_beat2", 64'(s_wvalid), 64'd1);
    reset = 1'b1;
    #1;
    check("rb_vr_async", 64'(vr_s), 64'd0);
    check("rb_id_err_clr", 64'(id_err), 64'd0);
    @(negedge clock);
    #1 check("rb_vr_edge", 64'(vr_s), 64'd0);
    reset = 1'b0; m_wvalid = '0;
    s_bvalid = 1'b1; s_bid = 6'h02;
    #1;
    check("rb_no_b", 64'(m_bvalid), 64'd0);
    check("rb_no_bready", 64'(s_bready), 64'd0);
    @(negedge clock);
    #1 check("rb_still_idle", 64'(vr_s), 64'd0);
    s_bvalid = 1'b0;
    m_awvalid = 3'b100; m_awid[11:8] = 4'd7;
    @(negedge clock); #1;
    check("rb_regrant", 64'(s_awid), 64'h27);
    check("rb_regrant_rdy", 64'(m_awready), 64'b100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
